clock_enable_ctrl: RTL
======================

// Module: clock_enable_ctrl
// PURPOSE
// - Synchronous, runtime-programmable replacement for ripple clock division: one clock, NCH channels.
// - Each channel emits a one-cycle clock-enable pulse (tick_en) every div cycles.
// - A config FSM serialises divisor updates and commits each one only at the target channel's
//   terminal count, so enables never see a runt period. Sits between a CPU/config master and
//   any logic that consumes slow rates (video, audio, timers).
// PARAMETERS
// - NCH   4  number of enable channels (1..16)
// - DIVW  8  divisor/counter width; legal divisor 0..2**DIVW-1
// PORTS
// - clk        in   1                 sole clock; all state updates on posedge clk
// - reset      in   1                 synchronous, active-high reset
// - cfg_valid  in   1                 config request valid
// - cfg_ready  out  1                 config request accepted when cfg_valid&&cfg_ready
// - cfg_ch     in   $clog2(NCH)       target channel (NCH==1: width 1, value ignored)
// - cfg_div    in   DIVW              new divisor; 0 = channel disabled
// - tick_en    out  NCH               per-channel one-cycle enable pulse
// - active     out  NCH               bit i = committed divisor of channel i is nonzero
// - clk_sq     out  NCH               only with CLKEN_SQUARE_OUT_EN; see CONFIGURATION
// BEHAVIOUR
// - Reset: every div=0, cnt=0, tick_en=0, active=0, clk_sq=0, FSM=IDLE, cfg_ready=1.
//   Reset mid-update discards the pending request; no channel is committed.
// - Channel i, div=D>0: cnt counts 0..D-1 then wraps to 0.
//   tick_en[i] is combinational (cnt==D-1): D=1 -> high every cycle; D=3 -> high 1 of 3 cycles.
// - Channel i, D=0: cnt held at 0, tick_en[i]=0.
// - FSM IDLE: cfg_ready=1. Handshake at edge T latches {pend_ch,pend_div}; FSM -> WAIT_TC.
// - FSM WAIT_TC: cfg_ready=0. At the first edge where the target channel has tick_en=1 or D=0:
//   - div<=pend_div, cnt<=0, FSM -> IDLE (cfg_ready=1 the following cycle).
//   - Disabled target: commit at edge T+1 (one-cycle latency).
//   - Running target: commit at the edge closing its current period; that final tick still fires
//     at the old rate, and the first new-rate tick is pend_div cycles later.
// - Commit of a divisor equal to the current one still waits for TC; the phase is unchanged.
// - Commit of 0 stops the channel after its final old-rate tick.
// - cfg_ch>=NCH (NCH not a power of 2): request accepted, FSM stays IDLE, nothing changes.
// - Channels other than the target run undisturbed throughout.
// - Only one request is outstanding at a time; there is no queue.
// - Widths: cnt and div are DIVW bits; the compare is cnt==div-1, evaluated only when div!=0,
//   so it never underflows.
// CONFIGURATION
// - CLKEN_SQUARE_OUT_EN defined:
//   - clk_sq[i] toggles on every edge where tick_en[i]=1 -> 50% square wave of period 2*D.
//   - clk_sq[i] is held at its current level while D=0, and cleared to 0 by reset.
//   - clk_sq is data, never used as a clock.
// - CLKEN_SQUARE_OUT_EN undefined: the clk_sq port and its flops do not exist.
// STRUCTURE
// - Shared package clock_enable_pkg:
//   - cfg_state_t enum {CFG_IDLE, CFG_WAIT_TC}
//   - DIV_OFF=0 constant
// - Sub-module clock_enable_chan (one per channel via generate):
//   - holds cnt/div (plus the clk_sq flop when enabled) and produces tick_en.
//   - commit input: when asserted, loads the new divisor and clears cnt.
// - Top: config FSM, pending registers, commit decode.
// TESTING
// - Reset, then 20 idle cycles -> tick_en=0, active=0, cfg_ready=1 throughout.
// - cfg ch0 div=1 -> commit next edge; tick_en[0]=1 every cycle; active[0]=1.
// - cfg ch1 div=4, then div=2 sent mid-period:
//   - the remaining div=4 tick fires on schedule; cfg_ready stays 0 until that edge.
//   - afterwards ticks every 2 cycles.
// - ch2 running div=3, cfg ch2 div=0 -> one final tick, then tick_en[2]=0 and active[2]=0.
//   ch0/ch1 tick spacing is unchanged throughout.
// - Assert reset while FSM=WAIT_TC (ch3 div=200 pending) -> next cycle: all channels off,
//   cfg_ready=1, no commit.
// - With CLKEN_SQUARE_OUT_EN, ch0 div=5 -> clk_sq[0] is high 5 cycles and low 5 cycles;
//   without the macro the build has no clk_sq port.

Source files
------------

// File: rtl/clock_enable_pkg.sv
// Shared types and constants for the clock-enable controller.
// The optional clk_sq square-wave outputs are controlled by CLKEN_SQUARE_OUT_EN.
package clock_enable_pkg;

    typedef enum logic [0:0] {
        CFG_IDLE    = 1'b0,
        CFG_WAIT_TC = 1'b1
    } cfg_state_t;

    // A divisor of zero means the channel is stopped.
    localparam int DIV_OFF = 0;

endpackage

// File: rtl/clock_enable_chan.sv
// One clock-enable channel: period counter, committed divisor and tick decode.
// With CLKEN_SQUARE_OUT_EN defined, a 50% square-wave flop (clk_sq) is added.
// clk_sq is a data signal and must never be used as a clock.
module clock_enable_chan
    import clock_enable_pkg::*;
#(
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            commit,
    input  logic [DIVW-1:0] new_div,
    output logic            tick_en,
    output logic            active
`ifdef CLKEN_SQUARE_OUT_EN
    ,
    output logic            clk_sq
`endif
);

    logic [DIVW-1:0] div;
    logic [DIVW-1:0] cnt;
    logic            enabled;

    // The compare only matters when div is nonzero, so div-1 never wraps.
    assign enabled = (div != DIVW'(DIV_OFF));
    assign tick_en = enabled && (cnt == (div - DIVW'(1)));
    assign active  = enabled;

    // Period counter; a commit restarts the period with the new divisor.
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
            cnt <= '0;
        end else if (commit) begin
            div <= new_div;
            cnt <= '0;
        end else if (!enabled || tick_en) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIVW'(1);
        end
    end

`ifdef CLKEN_SQUARE_OUT_EN
    // Toggle once per period; holds its level while the channel is stopped.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sq <= 1'b0;
        end else if (tick_en) begin
            clk_sq <= ~clk_sq;
        end
    end
`endif

endmodule

// File: rtl/clock_enable_ctrl.sv
// Runtime-programmable clock-enable generator with NCH channels.
// Divisor updates go through a one-deep config FSM and are committed only at the
// target channel's terminal count, so no enable period is ever shortened.
// Define CLKEN_SQUARE_OUT_EN to add the per-channel clk_sq square-wave outputs.
//
// state       | meaning
// ------------+---------------------------------------------------------
// CFG_IDLE    | ready for a request; cfg_ready=1
// CFG_WAIT_TC | request held in pend_*; commit at target's tick or if stopped
module clock_enable_ctrl
    import clock_enable_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int DIVW = 8,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [DIVW-1:0] cfg_div,
    output logic [NCH-1:0]  tick_en,
    output logic [NCH-1:0]  active
`ifdef CLKEN_SQUARE_OUT_EN
    ,
    output logic [NCH-1:0]  clk_sq
`endif
);

    cfg_state_t      state;
    cfg_state_t      state_nxt;
    logic [CHW-1:0]  pend_ch;
    logic [DIVW-1:0] pend_div;
    logic            cfg_ch_ok;
    logic            cfg_fire;
    logic [NCH-1:0]  sel;
    logic            tc_hit;
    logic [NCH-1:0]  commit;

    // Out-of-range channel numbers are accepted but leave the FSM idle.
    assign cfg_ch_ok = (NCH == 1) || (int'(cfg_ch) < NCH);
    assign cfg_fire  = cfg_valid && cfg_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CFG_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pending request capture on an accepted, in-range handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_ch  <= '0;
            pend_div <= '0;
        end else if (cfg_fire && cfg_ch_ok) begin
            pend_ch  <= cfg_ch;
            pend_div <= cfg_div;
        end
    end

    // Target decode: terminal count reached, or the target is stopped.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NCH; i++) begin
            sel[i] = (NCH == 1) || (pend_ch == CHW'(i));
        end
        tc_hit = |(sel & (tick_en | ~active));
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            CFG_IDLE: begin
                if (cfg_fire && cfg_ch_ok) begin
                    state_nxt = CFG_WAIT_TC;
                end
            end
            CFG_WAIT_TC: begin
                if (tc_hit) begin
                    state_nxt = CFG_IDLE;
                end
            end
            default: state_nxt = CFG_IDLE;
        endcase
    end

    // FSM outputs: handshake ready and the per-channel commit strobe.
    always_comb begin
        cfg_ready = (state == CFG_IDLE);
        commit    = '0;
        if (state == CFG_WAIT_TC && tc_hit) begin
            commit = sel;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clock_enable_chan #(
            .DIVW(DIVW)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .commit  (commit[g]),
            .new_div (pend_div),
            .tick_en (tick_en[g]),
            .active  (active[g])
`ifdef CLKEN_SQUARE_OUT_EN
            ,
            .clk_sq  (clk_sq[g])
`endif
        );
    end

endmodule
